// File: rtl/base_ram_pkg.sv
// base_ram_pkg: shared widths and types for the CAM base memory.
//   DATA_W - stored word width
//   ADDR_W - entry address width
//   DEPTH  - number of entries (2**ADDR_W)
package base_ram_pkg;

  localparam int unsigned DATA_W = 14;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 4096;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage : base_ram_pkg

// File: rtl/base_ram_array.sv
// base_ram_array: DEPTH x DATA_W synchronous-write / synchronous-read RAM
// with a synchronously clearable read register, inferable as block RAM.
// Ports:
//   clk      - clock, rising edge
//   we_i     - write enable (mem[addr_i] <= wdata_i)
//   re_i     - read enable (rdata_o <= mem[addr_i])
//   rd_clr_i - clear read register to zero (wins over re_i)
//   addr_i   - shared read/write address
//   wdata_i  - write data
//   rdata_o  - registered read data
module base_ram_array
  import base_ram_pkg::*;
(
  input  logic  clk,
  input  logic  we_i,
  input  logic  re_i,
  input  logic  rd_clr_i,
  input  addr_t addr_i,
  input  data_t wdata_i,
  output data_t rdata_o
);

  data_t mem_q [DEPTH];
  data_t rd_q;

  // Storage array write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Output register: sync clear maps onto the RAM output-register reset.
  always_ff @(posedge clk) begin
    if (rd_clr_i) begin
      rd_q <= '0;
    end else if (re_i) begin
      rd_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rd_q;

endmodule : base_ram_array

// File: rtl/base_ram.sv
// base_ram: 4096 x 14 base memory of the image CAM datapath.
// Write stores din at addr and marks the entry valid; match returns the
// stored word and a hit flag one cycle later if the entry is valid.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (clears valid bits, dout, hit)
//   we       - write enable (priority over match_en)
//   match_en - lookup enable
//   din      - write data
//   addr     - entry address for write and lookup
//   dout     - registered lookup data (0 on miss/reset, held otherwise)
//   hit      - registered single-cycle hit qualifier
module base_ram
  import base_ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              match_en,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              hit
);

  logic [DEPTH-1:0] valid_q;
  logic             hit_q;
  logic             hit_d;
  logic             wr_s;
  logic             rd_s;
  logic             rd_clr_s;
  logic             entry_valid_s;

  assign entry_valid_s = valid_q[addr];

  // Priority decode: reset, then write, then lookup, then idle.
  always_comb begin
    wr_s     = 1'b0;
    rd_s     = 1'b0;
    rd_clr_s = 1'b0;
    hit_d    = 1'b0;
    if (rst) begin
      rd_clr_s = 1'b1;
    end else if (we) begin
      wr_s  = 1'b1;
      hit_d = hit_q;
    end else if (match_en) begin
      if (entry_valid_s) begin
        rd_s  = 1'b1;
        hit_d = 1'b1;
      end else begin
        // Miss forces dout to zero so unwritten entries never leak data.
        rd_clr_s = 1'b1;
      end
    end else begin
      hit_d = 1'b0;
    end
  end

  // Valid-bit vector: cleared on reset, set by each write.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_s) begin
      valid_q[addr] <= 1'b1;
    end
  end

  // Hit qualifier register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  // The array's read register is the dout register: it only loads on a
  // valid lookup, clears on reset/miss, and otherwise holds.
  base_ram_array u_array (
    .clk      (clk),
    .we_i     (wr_s),
    .re_i     (rd_s),
    .rd_clr_i (rd_clr_s),
    .addr_i   (addr),
    .wdata_i  (din),
    .rdata_o  (dout)
  );

  assign hit = hit_q;

endmodule : base_ram

// File: tb/tb_base_ram.sv
// tb_base_ram: self-checking bench for base_ram with a behavioural model.
module tb_base_ram;

  logic        clk;
  logic        rst;
  logic        we;
  logic        match_en;
  logic [13:0] din;
  logic [11:0] addr;
  logic [13:0] dout;
  logic        hit;

  int vectors;
  int miscompares;

  // Reference model state
  logic [13:0] m_mem   [4096];
  bit          m_valid [4096];
  logic [13:0] m_dout;
  logic        m_hit;

  base_ram dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .match_en (match_en),
    .din      (din),
    .addr     (addr),
    .dout     (dout),
    .hit      (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive on the falling edge, update the model at the rising
  // edge, leave outputs settled 1 time unit later for the caller to check.
  task automatic apply(input logic r, input logic w, input logic m,
                       input logic [13:0] d, input logic [11:0] a);
    @(negedge clk);
    rst = r; we = w; match_en = m; din = d; addr = a;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4096; i++) m_valid[i] = 1'b0;
      m_dout = 14'd0;
      m_hit  = 1'b0;
    end else if (w) begin
      m_mem[a]   = d;
      m_valid[a] = 1'b1;
    end else if (m) begin
      if (m_valid[a]) begin
        m_dout = m_mem[a];
        m_hit  = 1'b1;
      end else begin
        m_dout = 14'd0;
        m_hit  = 1'b0;
      end
    end else begin
      m_hit = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 1'b0, 14'd0, 12'd0);
    apply(1'b1, 1'b0, 1'b0, 14'd0, 12'd0);
    vectors++;
    if (dout !== 14'd0 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state dout=%h hit=%b expected dout=0000 hit=0", dout, hit);
    end
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'hE00);
    vectors++;
    if (dout !== 14'd0 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_unwritten dout=%h hit=%b expected dout=0000 hit=0", dout, hit);
    end
  endtask

  task automatic test_write_match();
    apply(1'b0, 1'b1, 1'b0, 14'h0001, 12'hE00);
    apply(1'b0, 1'b1, 1'b0, 14'h0002, 12'hE10);
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'hE00);
    vectors++;
    if (dout !== 14'h0001 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL match_E00 dout=%h hit=%b expected dout=0001 hit=1", dout, hit);
    end
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'hE10);
    vectors++;
    if (dout !== 14'h0002 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL match_E10 dout=%h hit=%b expected dout=0002 hit=1", dout, hit);
    end
  endtask

  task automatic test_priority();
    apply(1'b0, 1'b1, 1'b1, 14'h3FFF, 12'h005);
    vectors++;
    if (dout !== 14'h0002 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL priority_hold dout=%h hit=%b expected dout=0002 hit=1", dout, hit);
    end
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'h005);
    vectors++;
    if (dout !== 14'h3FFF || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL priority_match dout=%h hit=%b expected dout=3fff hit=1", dout, hit);
    end
  endtask

  task automatic test_overwrite_bounds();
    apply(1'b0, 1'b1, 1'b0, 14'h0AAA, 12'hFFF);
    apply(1'b0, 1'b1, 1'b0, 14'h1555, 12'hFFF);
    apply(1'b0, 1'b1, 1'b0, 14'h0123, 12'h000);
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'hFFF);
    vectors++;
    if (dout !== 14'h1555 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL match_FFF dout=%h hit=%b expected dout=1555 hit=1", dout, hit);
    end
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'h000);
    vectors++;
    if (dout !== 14'h0123 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL match_000 dout=%h hit=%b expected dout=0123 hit=1", dout, hit);
    end
  endtask

  task automatic test_idle_hold();
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'hE00);
    vectors++;
    if (dout !== 14'h0001 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_pre dout=%h hit=%b expected dout=0001 hit=1", dout, hit);
    end
    apply(1'b0, 1'b0, 1'b0, 14'd0, 12'h123);
    vectors++;
    if (dout !== 14'h0001 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold dout=%h hit=%b expected dout=0001 hit=0", dout, hit);
    end
  endtask

  task automatic test_reset_midop();
    apply(1'b1, 1'b1, 1'b0, 14'h0007, 12'hE00);
    vectors++;
    if (dout !== 14'd0 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state dout=%h hit=%b expected dout=0000 hit=0", dout, hit);
    end
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'hE00);
    vectors++;
    if (dout !== 14'd0 || hit !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_match dout=%h hit=%b expected dout=0000 hit=0", dout, hit);
    end
  endtask

  task automatic test_random();
    logic r, w, m;
    logic [13:0] d;
    logic [11:0] a;
    for (int n = 0; n < 600; n++) begin
      r = ($urandom_range(0, 49) == 0);
      w = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 3) != 0);
      d = 14'($urandom);
      // Small address pool so writes and lookups collide often.
      case ($urandom_range(0, 3))
        0: a = 12'h000;
        1: a = 12'hFFF;
        default: a = 12'($urandom_range(0, 15)) | 12'hA00;
      endcase
      apply(r, w, m, d, a);
      vectors++;
      if (dout !== m_dout || hit !== m_hit) begin
        miscompares++;
        $display("FAIL random[%0d] dout=%h hit=%b expected dout=%h hit=%b",
                 n, dout, hit, m_dout, m_hit);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 1'b0, 14'h2468, 12'h7A5);
    apply(1'b0, 1'b0, 1'b1, 14'd0, 12'h7A5);
    vectors++;
    if (dout !== 14'h2468 || hit !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_match dout=%h hit=%b expected dout=2468 hit=1", dout, hit);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; we = 1'b0; match_en = 1'b0; din = 14'd0; addr = 12'd0;
    m_dout = 14'd0;
    m_hit  = 1'b0;
    test_reset();
    test_write_match();
    test_priority();
    test_overwrite_bounds();
    test_idle_hold();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_base_ram
